xbar_port_arbiter: RTL and testbench
====================================

# xbar_port_arbiter

Arbitrates three bus controllers (index 0 instruction fetch, 1 LSU, 2 debugger) onto one shared memory/peripheral port using the crossbar's req/ready protocol. It sits in front of any single-port target that more than one controller must reach. It registers the winning request, holds it on the port until the target answers, and routes the response back. A watchdog aborts transactions the target never completes.

## Interface
Parameters:
- ADDR_WIDTH, 14, word-address width on both sides.
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority 2 > 1 > 0.
- TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog. Range 0..65535.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- c_req_i  in  3  request per controller; held high until its c_ready_o bit pulses.
- c_addr_i  in  3*ADDR_WIDTH  packed word addresses; controller k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- c_wen_i  in  3  write enable; bit 0 is ignored and treated as 0 (fetch is read-only).
- c_wdata_i  in  96  packed write data, 32 bits per controller.
- c_be_i  in  12  packed byte enables, 4 bits per controller.
- c_rdata_o  out  32  response data, shared by all controllers; valid only with a c_ready_o bit.
- c_ready_o  out  3  one-cycle completion pulse to the granted controller.
- p_req_o  out  1  target request.
- p_addr_o  out  ADDR_WIDTH  target address.
- p_wen_o  out  1  target write enable.
- p_wdata_o  out  32  target write data.
- p_be_o  out  4  target byte enables.
- p_rdata_i  in  32  target read data; valid with p_ready_i.
- p_ready_i  in  1  target completion pulse.
- grant_o  out  3  one-hot granted controller; 0 when IDLE.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM has two states, IDLE and BUSY. Reset state is IDLE.
- IDLE, any c_req_i set: choose a winner g, then on the clock edge:
  - latch c_addr/c_wen/c_wdata/c_be of g into the p_* registers;
  - set grant_q to one-hot g;
  - clear the watchdog counter;
  - enter BUSY.
- IDLE, no request: p_* registers hold their values. p_req_o = 0.
- Round-robin: a last-grant pointer starts at 2 after reset. Search order is last+1, last+2, last+3 (mod 3). The pointer updates to g on every grant.
- Fixed priority (ROUND_ROBIN = 0): highest requesting index wins. The pointer is unused.
- BUSY: p_req_o = 1 and p_* outputs are stable. Controller inputs are ignored, including a controller dropping its request (protocol violation; the transaction still completes).
- BUSY, p_ready_i = 1: c_ready_o[g] = 1 and c_rdata_o = p_rdata_i, combinationally in that cycle. Enter IDLE on the edge.
- BUSY, p_ready_i = 0: watchdog counter increments, saturating at 16 bits.
- Abort (TIMEOUT ≠ 0, p_ready_i = 0, counter = TIMEOUT-1):
  - c_ready_o[g] = 1, c_rdata_o = 32'h0, timeout_o = 1;
  - enter IDLE. The target must tolerate an abandoned request.
- p_ready_i in the same cycle as the abort condition: normal completion; no timeout_o.
- p_ready_i while IDLE is ignored.
- c_rdata_o = 0 whenever no c_ready_o bit is set.

## Timing
- Reset values: p_req_o, p_addr_o, p_wen_o, p_wdata_o, p_be_o, c_ready_o, c_rdata_o, grant_o, timeout_o all 0. Round-robin pointer = 2. Watchdog counter = 0.
- rst_i asserted in BUSY: state is IDLE at the next edge and all outputs are at reset values from that cycle. No c_ready_o pulse is issued for the dropped transaction.
- Request latency: c_req_i sampled in cycle N (IDLE) gives p_req_o = 1 from N+1.
- Response latency: p_ready_i in cycle M gives c_ready_o in the same cycle M (0 added).
- Back-to-back requests: p_req_o is low in M+1 while the FSM re-arbitrates in IDLE; the next p_req_o rises at M+2. Minimum transaction period is 2 cycles plus target latency.
- Abort timing: with p_req_o first high in N+1 and no response, the abort fires in cycle N+TIMEOUT.

## Test plan
- Single read: c_req_i = 3'b001, addr = 0x10, target answers p_rdata_i = 0xCAFE0001 in cycle 3 of BUSY -> p_addr_o = 0x10, p_wen_o = 0, c_ready_o = 3'b001 with c_rdata_o = 0xCAFE0001 in that same cycle.
- Round-robin, all three requesting continuously with a 1-cycle target -> grant order 0, 1, 2, 0, 1, 2; p_req_o low for exactly 1 cycle between grants.
- Fixed priority (ROUND_ROBIN = 0), same stimulus -> controller 2 always wins; 0 and 1 are starved.
- Write via LSU: wen = 1, wdata = 0xA5A5A5A5, be = 4'b0011 -> the p_* fields match exactly and stay stable until p_ready_i. Controller 0 with wen = 1 -> p_wen_o = 0.
- Watchdog: TIMEOUT = 4, target never ready -> abort in the 4th BUSY cycle with c_ready_o[g] = 1, c_rdata_o = 0, timeout_o = 1. A second run with p_ready_i arriving in that same 4th cycle -> normal completion, no timeout_o.
- Reset mid-transaction: rst_i in the 2nd BUSY cycle -> the next cycle has p_req_o = 0 and grant_o = 0, with no c_ready_o pulse. A subsequent c_req_i = 3'b111 is granted to controller 0 first.

Source files
------------

// File: rtl/xbar_port_arbiter.sv
// ============================================================================
// xbar_port_arbiter: three bus controllers share one target port through a
// registered arbiter with response routing and a transaction watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xbar_port_arbiter #(
  parameter int ADDR_WIDTH  = 14,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2:0]              c_req_i,
  input  logic [3*ADDR_WIDTH-1:0] c_addr_i,
  input  logic [2:0]              c_wen_i,
  input  logic [95:0]             c_wdata_i,
  input  logic [11:0]             c_be_i,
  output logic [31:0]             c_rdata_o,
  output logic [2:0]              c_ready_o,
  output logic                    p_req_o,
  output logic [ADDR_WIDTH-1:0]   p_addr_o,
  output logic                    p_wen_o,
  output logic [31:0]             p_wdata_o,
  output logic [3:0]              p_be_o,
  input  logic [31:0]             p_rdata_i,
  input  logic                    p_ready_i,
  output logic [2:0]              grant_o,
  output logic                    timeout_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic [2:0]              grant_q;
  logic [1:0]              last_q;
  logic [15:0]             wd_cnt_q;

  logic [1:0]              cand [3];
  logic [1:0]              win_idx;
  logic                    win_valid;
  logic [2:0]              win_onehot;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_wen;
  logic [31:0]             sel_wdata;
  logic [3:0]              sel_be;
  logic [2:0]              wen_eff;
  logic                    done;
  logic                    abort;

  // Search order: fixed 2>1>0, or rotating starting after the last winner.
  always_comb begin
    cand[0] = 2'd2;
    cand[1] = 2'd1;
    cand[2] = 2'd0;
    if (ROUND_ROBIN != 0) begin
      case (last_q)
        2'd0: begin
          cand[0] = 2'd1; cand[1] = 2'd2; cand[2] = 2'd0;
        end
        2'd1: begin
          cand[0] = 2'd2; cand[1] = 2'd0; cand[2] = 2'd1;
        end
        default: begin
          cand[0] = 2'd0; cand[1] = 2'd1; cand[2] = 2'd2;
        end
      endcase
    end
  end

  always_comb begin
    win_idx   = cand[2];
    win_valid = |c_req_i;
    for (int i = 2; i >= 0; i--) begin
      if (c_req_i[cand[i]]) win_idx = cand[i];
    end
    win_onehot = 3'b001 << win_idx;
  end

  // Fetch port is read-only regardless of what it drives on its wen bit.
  assign wen_eff = c_wen_i & 3'b110;

  always_comb begin
    sel_addr  = c_addr_i[0 +: ADDR_WIDTH];
    sel_wen   = wen_eff[0];
    sel_wdata = c_wdata_i[31:0];
    sel_be    = c_be_i[3:0];
    case (win_idx)
      2'd1: begin
        sel_addr  = c_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
        sel_wen   = wen_eff[1];
        sel_wdata = c_wdata_i[63:32];
        sel_be    = c_be_i[7:4];
      end
      2'd2: begin
        sel_addr  = c_addr_i[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wen   = wen_eff[2];
        sel_wdata = c_wdata_i[95:64];
        sel_be    = c_be_i[11:8];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (p_ready_i) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      grant_q  <= '0;
      last_q   <= 2'd2;
      wd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && win_valid) begin
        addr_q   <= sel_addr;
        wen_q    <= sel_wen;
        wdata_q  <= sel_wdata;
        be_q     <= sel_be;
        grant_q  <= win_onehot;
        wd_cnt_q <= '0;
        last_q   <= win_idx;
      end else if ((state_q == S_BUSY) && !p_ready_i && (wd_cnt_q != 16'hFFFF)) begin
        wd_cnt_q <= wd_cnt_q + 16'd1;
      end
    end
  end

  // A transaction dropped by reset must not signal completion.
  assign c_ready_o = ((done || abort) && !rst_i) ? grant_q : 3'b000;
  assign c_rdata_o = (done && !rst_i) ? p_rdata_i : 32'h0;
  assign timeout_o = abort && !rst_i;

  assign p_req_o   = (state_q == S_BUSY);
  assign p_addr_o  = addr_q;
  assign p_wen_o   = wen_q;
  assign p_wdata_o = wdata_q;
  assign p_be_o    = be_q;
  assign grant_o   = (state_q == S_BUSY) ? grant_q : 3'b000;

endmodule

`default_nettype wire

// File: tb/tb_xbar_port_arbiter.sv
// ============================================================================
// tb_xbar_port_arbiter: randomized scoreboard bench against a transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xbar_port_arbiter;

  localparam int AW = 14;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: round-robin, watchdog = 4
  logic             rst;
  logic [2:0]       c_req;
  logic [3*AW-1:0]  c_addr;
  logic [2:0]       c_wen;
  logic [95:0]      c_wdata;
  logic [11:0]      c_be;
  logic [31:0]      c_rdata;
  logic [2:0]       c_ready;
  logic             p_req;
  logic [AW-1:0]    p_addr;
  logic             p_wen;
  logic [31:0]      p_wdata;
  logic [3:0]       p_be;
  logic [31:0]      p_rdata;
  logic             p_ready;
  logic [2:0]       grant;
  logic             tmo;

  xbar_port_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1), .TIMEOUT(TO)) u_rr (
    .clk_i(clk), .rst_i(rst), .c_req_i(c_req), .c_addr_i(c_addr), .c_wen_i(c_wen),
    .c_wdata_i(c_wdata), .c_be_i(c_be), .c_rdata_o(c_rdata), .c_ready_o(c_ready),
    .p_req_o(p_req), .p_addr_o(p_addr), .p_wen_o(p_wen), .p_wdata_o(p_wdata),
    .p_be_o(p_be), .p_rdata_i(p_rdata), .p_ready_i(p_ready), .grant_o(grant),
    .timeout_o(tmo)
  );

  // second DUT: fixed priority, watchdog disabled
  logic             f_rst;
  logic [2:0]       f_req;
  logic [3*AW-1:0]  f_addr;
  logic [31:0]      f_rdata;
  logic [2:0]       f_ready;
  logic             f_preq;
  logic [AW-1:0]    f_paddr;
  logic             f_pwen;
  logic [31:0]      f_pwdata;
  logic [3:0]       f_pbe;
  logic             f_pready;
  logic [2:0]       f_grant;
  logic             f_tmo;

  xbar_port_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(0), .TIMEOUT(0)) u_fp (
    .clk_i(clk), .rst_i(f_rst), .c_req_i(f_req), .c_addr_i(f_addr), .c_wen_i(3'b000),
    .c_wdata_i(96'h0), .c_be_i(12'h0), .c_rdata_o(f_rdata), .c_ready_o(f_ready),
    .p_req_o(f_preq), .p_addr_o(f_paddr), .p_wen_o(f_pwen), .p_wdata_o(f_pwdata),
    .p_be_o(f_pbe), .p_rdata_i(32'h1234_5678), .p_ready_i(f_pready), .grant_o(f_grant),
    .timeout_o(f_tmo)
  );

  typedef struct packed {
    logic [2:0]    grant;
    logic [AW-1:0] addr;
    logic          wen;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } gnt_t;

  typedef struct packed {
    logic [2:0]  ready;
    logic [31:0] rdata;
    logic        to;
  } cmp_t;

  gnt_t       gq[$];
  cmp_t       cq[$];
  logic [2:0] gseq[$];
  int         total = 0;
  int         bad   = 0;
  int         n_to  = 0;
  logic       mon_en = 1'b0;
  logic       exp_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT presentation against queued expectations.
  gnt_t cur;
  logic prev_preq = 1'b0;
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      check("p_req", {63'h0, p_req}, {63'h0, exp_busy});
      if (p_req && !prev_preq) begin
        if (gq.size() == 0) begin
          check("grant_unexpected", 64'h1, 64'h0);
        end else begin
          cur = gq.pop_front();
          check("grant_fields", 64'({grant, p_addr, p_wen, p_wdata, p_be}), 64'(cur));
          gseq.push_back(grant);
        end
      end else if (p_req) begin
        check("hold_fields", 64'({grant, p_addr, p_wen, p_wdata, p_be}), 64'(cur));
      end else begin
        check("idle_grant", {61'h0, grant}, 64'h0);
      end
      if (c_ready != 3'b000) begin
        if (cq.size() == 0) begin
          check("ready_unexpected", {61'h0, c_ready}, 64'h0);
        end else begin
          cmp_t e;
          e = cq.pop_front();
          check("completion", 64'({c_ready, c_rdata, tmo}), 64'(e));
          if (tmo) n_to++;
        end
      end else begin
        check("quiet_outputs", {31'h0, c_rdata, tmo}, 64'h0);
      end
      prev_preq = p_req;
    end
  end

  // Reference model state: transaction level, indices are controller numbers.
  bit            act   [3];
  logic [AW-1:0] m_addr[3];
  logic          m_wen [3];
  logic [31:0]   m_wd  [3];
  logic [3:0]    m_be  [3];
  bit            m_busy;
  int            m_last, m_cnt, m_g, lat;

  initial begin
    logic [2:0] exp_seq [6];
    bit   phase0, do_rst, found;
    int   fp_to, fp_rdy;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    rst = 1'b1; c_req = '0; c_addr = '0; c_wen = '0; c_wdata = '0; c_be = '0;
    p_rdata = '0; p_ready = 1'b0;
    f_rst = 1'b1; f_req = '0; f_addr = '0; f_pready = 1'b0;
    for (int k = 0; k < 3; k++) act[k] = 0;
    m_busy = 0; m_last = 2; m_cnt = 0; m_g = 0; lat = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_p_req",   {63'h0, p_req}, 64'h0);
    check("rst_p_addr",  64'(p_addr), 64'h0);
    check("rst_p_wen",   {63'h0, p_wen}, 64'h0);
    check("rst_p_wdata", 64'(p_wdata), 64'h0);
    check("rst_p_be",    64'(p_be), 64'h0);
    check("rst_c_ready", 64'(c_ready), 64'h0);
    check("rst_c_rdata", 64'(c_rdata), 64'h0);
    check("rst_grant",   64'(grant), 64'h0);
    check("rst_timeout", {63'h0, tmo}, 64'h0);
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      phase0 = (cyc < 40);
      for (int k = 0; k < 3; k++) begin
        if (!act[k] && (phase0 || $urandom_range(0, 3) == 0)) begin
          act[k]    = 1;
          m_addr[k] = AW'($urandom);
          m_wen[k]  = 1'($urandom);
          m_wd[k]   = $urandom;
          m_be[k]   = 4'($urandom);
        end
        c_req[k]            = act[k];
        c_addr[k*AW +: AW]  = m_addr[k];
        c_wen[k]            = m_wen[k];
        c_wdata[k*32 +: 32] = m_wd[k];
        c_be[k*4 +: 4]      = m_be[k];
      end
      do_rst  = !phase0 && m_busy && ($urandom_range(0, 60) == 0);
      rst     = do_rst;
      p_rdata = $urandom;
      p_ready = m_busy ? (m_cnt == lat) : 1'($urandom);
      exp_busy = m_busy;

      if (do_rst) begin
        m_busy = 0; m_last = 2; m_cnt = 0;
        for (int k = 0; k < 3; k++) act[k] = 0;
      end else if (!m_busy) begin
        found = 0;
        for (int i = 1; i <= 3; i++) begin
          int idx;
          idx = (m_last + i) % 3;
          if (!found && act[idx]) begin
            found = 1;
            m_g   = idx;
          end
        end
        if (found) begin
          gq.push_back('{grant: 3'(1 << m_g), addr: m_addr[m_g],
                         wen: (m_g == 0) ? 1'b0 : m_wen[m_g],
                         wdata: m_wd[m_g], be: m_be[m_g]});
          m_busy = 1; m_cnt = 0; m_last = m_g;
          lat = phase0 ? 0 : $urandom_range(0, 6);
        end
      end else if (p_ready) begin
        cq.push_back('{ready: 3'(1 << m_g), rdata: p_rdata, to: 1'b0});
        act[m_g] = 0; m_busy = 0;
      end else if (m_cnt == TO - 1) begin
        cq.push_back('{ready: 3'(1 << m_g), rdata: 32'h0, to: 1'b1});
        act[m_g] = 0; m_busy = 0;
      end else begin
        m_cnt++;
      end
    end

    @(negedge clk);
    rst = 1'b1; c_req = '0; p_ready = 1'b0; exp_busy = m_busy;
    #2;
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < gseq.size()) check("rr_order", 64'(gseq[i]), 64'(exp_seq[i]));
      else check("rr_order_missing", 64'h0, 64'h1);
    end
    check("timeouts_seen", {63'h0, n_to > 0}, 64'h1);
    check("grant_queue_empty", 64'(gq.size()), 64'h0);
    check("cmp_queue_empty", 64'(cq.size()), 64'h0);

    // Fixed priority: everyone requests forever, only controller 2 is served.
    f_addr = {14'h0222, 14'h0111, 14'h0010};
    @(negedge clk);
    f_rst = 1'b0; f_req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      f_pready = f_preq;
      #1;
      if (f_ready != 3'b000) begin
        check("fp_winner", 64'(f_ready), 64'h4);
        check("fp_addr", 64'(f_paddr), 64'h0222);
        check("fp_rdata", 64'(f_rdata), 64'h1234_5678);
      end
    end
    // Watchdog disabled: the transaction waits indefinitely.
    @(negedge clk);
    f_pready = 1'b0;
    fp_to = 0; fp_rdy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (f_tmo) fp_to++;
      if (f_ready != 3'b000) fp_rdy++;
    end
    check("fp_no_timeout", 64'(fp_to), 64'h0);
    check("fp_no_ready", 64'(fp_rdy), 64'h0);
    check("fp_still_req", {63'h0, f_preq}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
